// File: rtl/pp_seq_mul.sv
// Sequential signed WxW multiplier: accumulates ROWS partial-product rows per cycle,
// with the MSB row of a negated for two's-complement weighting.
module pp_seq_mul #(
    parameter int W    = 16,
    parameter int ROWS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam int N  = W / ROWS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_r, b_r, a_nxt, b_nxt;
    logic [2*W-1:0] acc, acc_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    logic [2*W-1:0] b_ext, row, group_sum;
    logic [IW-1:0]  row_idx;

    // Sum of the ROWS partial products selected by the current group counter.
    always_comb begin
        group_sum = '0;
        row       = '0;
        row_idx   = '0;
        b_ext     = {{W{b_r[W-1]}}, b_r};
        for (int unsigned j = 0; j < ROWS; j++) begin
            row_idx = IW'(int'(cnt) * ROWS + int'(j));
            row     = a_r[row_idx] ? (b_ext << row_idx) : '0;
            if (row_idx == IW'(W - 1)) begin
                row = -row;
            end
            group_sum = group_sum + row;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_r;
        b_nxt     = b_r;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    acc_nxt = acc + group_sum;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy = !in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            a_r   <= a_nxt;
            b_r   <= b_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign product = acc;

endmodule

// File: doc/pp_seq_mul.md
# pp_seq_mul

Multi-cycle sequencer for the signed 16x16 partial-product datapath. It accepts an operand pair over a valid/ready handshake and builds the product over several cycles. Each cycle it generates and accumulates `ROWS` partial-product rows, with the MSB row of A negated for two's-complement weighting. The result is presented on a valid/ready output. It is the area-reduced alternative to the full Wallace-tree array and sits between the operand source and the result consumer.

## Interface
- `W`, 16: operand width. Must be even and ≥ 4.
- `ROWS`, 4: partial-product rows processed per cycle. Must divide `W`. Number of accumulate cycles `N = W/ROWS`.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  W: signed multiplier (selects rows).
- `b`  in  W: signed multiplicand.
- `abort`  in  1: synchronous cancel of the operation in flight.
- `out_valid`  out  1: `product` valid.
- `out_ready`  in  1: consumer accepts `product`.
- `product`  out  2W: signed `a*b`, registered.
- `busy`  out  1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready=1`. On `in_valid&&in_ready`:
  - latch `a` and `b` into `a_r`/`b_r`;
  - set `acc=0` and `cnt=0`;
  - go to RUN.
- RUN: each cycle add the rows `i = cnt*ROWS .. cnt*ROWS+ROWS-1` to `acc`.
  - Row `i < W-1`: `a_r[i] ? sext(b_r) << i : 0`.
  - Row `W-1`: `a_r[W-1] ? -(sext(b_r) << (W-1)) : 0`.
  - `sext` is sign extension to 2W bits. All sums are taken modulo 2^(2W).
  - `cnt` increments. When the last group (`cnt==N-1`) is added, go to DONE.
- DONE: `out_valid=1`; `product` equals `acc` and is held stable. On `out_valid&&out_ready`, go to IDLE.
- `abort` in RUN or DONE: go to IDLE next edge, drop `out_valid`, no result delivered. `abort` in IDLE has no effect. `abort` takes priority over the last accumulate and over the output handshake in the same cycle.
- `in_ready` is low in RUN and DONE. Operands presented then are not consumed, and `a`/`b` changes do not affect the operation in flight.
- `product` is valid only while `out_valid=1`; outside DONE its value is don't-care to consumers but must be stable.
- Edge products: `(-2^(W-1))*(-2^(W-1)) = 2^(2W-2)` is exact, with no overflow in 2W bits.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `busy=0`, `product=0`, state IDLE, `cnt=0`.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Any in-flight result is lost.
- Accept at edge E0 → RUN during cycles after E0 through E(N-1). The final group is added at edge EN, where the state becomes DONE and `out_valid` rises. Latency is N edges from accept to `out_valid` (4 for the defaults; 16 for `ROWS=1`).
- Output handshake at edge Ek → IDLE after Ek. The next accept happens no earlier than edge Ek+1.
- Minimum issue interval: N+2 cycles with `out_ready` held high.
- `out_valid` stays high, and `product` stays unchanged, for as long as `out_ready=0`.
- `busy` equals `!in_ready`, combinational from state.

## Test plan
- Basic: `a=3`, `b=5`, `out_ready=1` → `out_valid` exactly 4 edges after accept, `product=0x0000000F`. Then `in_ready` returns next cycle.
- Signs: `a=-1`, `b=-1` → `0x00000001`. `a=-32768`, `b=32767` → `0xC0008000`. `a=-32768`, `b=-32768` → `0x40000000`. `a=0`, `b=-7` → `0x00000000`.
- Backpressure: `a=-3`, `b=7`, `out_ready=0` for 10 cycles → `out_valid` held, `product=0xFFFFFFEB` stable, `in_ready=0` throughout. Accepted exactly once after `out_ready=1`.
- Abort: `a=100`, `b=200`, pulse `abort` 2 cycles after accept → IDLE next edge, no `out_valid`. The next op `a=2`, `b=-4` → `0xFFFFFFF8`.
- Reset: assert `rst_n=0` mid-RUN, asynchronously between edges → outputs at reset values before the next edge. After release, `a=9`, `b=9` → `0x00000051`.
- Random: 10k random `a`/`b` with random `in_valid`/`out_ready`, for `ROWS` in {1, 2, 4, 16} → every product equals the reference signed multiply, latency equals `W/ROWS`, no lost or duplicated results.
